mips_multicycle_control: RTL

Multicycle MIPS main control FSM. Sequences each instruction through fetch, decode, execute, memory and write-back cycles, and drives every datapath control signal. That includes the 2-bit `reg_dst` select consumed by the write-register 3:1 mux (rt / rd / $ra). It sits directly upstream of that mux, the register file, the ALU control and the memory port, and stalls on a memory-ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 81 ++++++++
 rtl/mips_ctrl_decode.sv | 85 ++++++++
 rtl/mips_multicycle_control.sv | 89 ++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path. The datapath muxes
// and the ALU control import the same select constants as the control FSM.
package mips_ctrl_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int STATE_WIDTH  = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JAL       = 4'd12
  } state_t;

  // Write-register mux select
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // Register write-data source
  localparam logic [1:0] MEMTOREG_ALUOUT = 2'd0;
  localparam logic [1:0] MEMTOREG_MDR    = 2'd1;
  localparam logic [1:0] MEMTOREG_PC     = 2'd2;

  // ALU B operand source
  localparam logic [1:0] ALUSRCB_B       = 2'd0;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'd1;
  localparam logic [1:0] ALUSRCB_IMM     = 2'd2;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'd3;

  // ALU operation class handed to the ALU control
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  // Next-PC source
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // True for every opcode the FSM knows how to sequence.
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)   || (op == OP_JAL) ||
           (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational Moore output decode: state (plus mem_ready for the FETCH
// IR/PC write strobes) to the datapath control word. Reset forces all zeros.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   reset,
  output ctrl_t  ctrl
);

  // Per-state control word; anything not set for a state stays 0.
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = ALUSRCB_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = ALUSRCB_IMM_SH2;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_ADDR, S_ADDI_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALUSRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_READ: begin
          ctrl.mem_read = 1'b1;
          ctrl.ior_d    = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.reg_dst    = REGDST_RT;
          ctrl.mem_to_reg = MEMTOREG_MDR;
          ctrl.reg_write  = 1'b1;
        end
        S_MEM_WRITE: begin
          ctrl.mem_write = 1'b1;
          ctrl.ior_d     = 1'b1;
        end
        S_EXECUTE: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALUSRCB_B;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_R_WB: begin
          ctrl.reg_dst    = REGDST_RD;
          ctrl.mem_to_reg = MEMTOREG_ALUOUT;
          ctrl.reg_write  = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = ALUSRCB_B;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
        end
        S_ADDI_WB: begin
          ctrl.reg_dst    = REGDST_RT;
          ctrl.mem_to_reg = MEMTOREG_ALUOUT;
          ctrl.reg_write  = 1'b1;
        end
        S_JAL: begin
          ctrl.reg_dst    = REGDST_RA;
          ctrl.mem_to_reg = MEMTOREG_PC;
          ctrl.reg_write  = 1'b1;
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PCSRC_JUMP;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: state register and next-state sequencing.
// Memory handshake: a FETCH/MEM_READ/MEM_WRITE state holds while mem_ready=0
// and advances on the first edge at which mem_ready=1; other states ignore it.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    ior_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    reg_write,
  output logic                    alu_src_a,
  output logic [1:0]              reg_dst,
  output logic [1:0]              mem_to_reg,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              pc_source,
  output logic                    illegal_op,
  output logic [STATE_WIDTH-1:0]  state
);

  state_t state_q;
  ctrl_t  ctrl;

  // State register with next-state selection; unreachable codes recover to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:     state_q <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_q <= S_MEM_ADDR;
            OP_RTYPE:     state_q <= S_EXECUTE;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_JAL:       state_q <= S_JAL;
            OP_ADDI:      state_q <= S_ADDI_EXEC;
            default:      state_q <= S_FETCH;
          endcase
        end
        S_MEM_ADDR:  state_q <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  state_q <= mem_ready ? S_MEM_WB : S_MEM_READ;
        S_MEM_WRITE: state_q <= mem_ready ? S_FETCH : S_MEM_WRITE;
        S_EXECUTE:   state_q <= S_R_WB;
        S_ADDI_EXEC: state_q <= S_ADDI_WB;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  mips_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .reset     (reset),
    .ctrl      (ctrl)
  );

  // Unsupported opcode flagged for the single DECODE cycle, never under reset.
  always_comb begin
    illegal_op = !reset && (state_q == S_DECODE) && !is_legal_op(opcode);
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign ior_d         = ctrl.ior_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign state         = STATE_WIDTH'(state_q);

endmodule
